// File: rtl/instr_mem_prog.sv
// instr_mem_prog: programmable instruction memory with a load port and a
// single-cycle fetch port.
//
// A load session is opened by raising prog_en. Each accepted word is written
// at wr_ptr, and wr_ptr then advances. A session can hold at most DEPTH words.
// prog_en falling closes the session, and prog_count keeps the number of words
// loaded. Words offered while the memory is full are dropped, and the sticky
// prog_ovf flag is raised.
//
// Outside a session, a fetch request returns mem[fetch_addr] one cycle later.
// An address at or above prog_count returns a NOP (all zeros) with addr_err
// set. The array itself is never reset. Only words below prog_count are
// reachable.
//
// Load handshake: a word transfers on a rising edge where prog_valid and
// prog_ready are both high. prog_ready depends only on state and wr_ptr, never
// on prog_valid. Offering a word while prog_ready is low in LOAD drops the word
// and raises prog_ovf.
//
// Ports
//   clk, rst       : clock, asynchronous active-high reset
//   prog_en        : load session active
//   prog_valid     : prog_data carries a word
//   prog_data      : word to load
//   prog_ready     : a word is accepted this cycle
//   prog_ovf       : sticky, a word was offered while the memory was full
//   prog_count     : words loaded in the current or last session
//   fetch_req      : fetch request, only honoured in IDLE with prog_en low
//   fetch_addr     : word address to fetch
//   ins_out        : fetched word, registered
//   ins_valid      : one-cycle pulse, ins_out updated
//   addr_err       : qualifies ins_valid, address was not loaded
//   busy           : FSM is in LOAD (this is the observable FSM state)
module instr_mem_prog #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_en,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_ovf,
  output logic [ADDR_W:0]   prog_count,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] ins_out,
  output logic              ins_valid,
  output logic              addr_err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t state, state_nxt;

  // The write pointer is one bit wider than the address, so a full memory
  // (wr_ptr == DEPTH) is representable without wrapping. Because the pointer
  // and the loaded-word count always move together, a single register serves
  // as both.
  logic [ADDR_W:0]   wr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic sess_start;
  logic wr_en;
  logic ovf_set;
  logic fetch_go;
  logic fetch_hit;

  assign prog_count = wr_ptr;
  assign fetch_hit  = ({1'b0, fetch_addr} < wr_ptr);

  always_comb begin
    state_nxt  = state;
    prog_ready = 1'b0;
    busy       = 1'b0;
    sess_start = 1'b0;
    wr_en      = 1'b0;
    ovf_set    = 1'b0;
    fetch_go   = 1'b0;
    case (state)
      IDLE: begin
        // When a load request and a fetch request arrive together, the load wins.
        if (prog_en) begin
          state_nxt  = LOAD;
          sess_start = 1'b1;
        end else begin
          fetch_go = fetch_req;
        end
      end
      LOAD: begin
        busy       = 1'b1;
        prog_ready = (wr_ptr < DEPTH_C);
        wr_en      = prog_valid && prog_ready;
        ovf_set    = prog_valid && !prog_ready;
        if (!prog_en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      prog_ovf  <= 1'b0;
      ins_out   <= '0;
      ins_valid <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      state <= state_nxt;

      if (sess_start) begin
        wr_ptr   <= '0;
        prog_ovf <= 1'b0;
      end else begin
        if (wr_en)   wr_ptr   <= wr_ptr + 1'b1;
        if (ovf_set) prog_ovf <= 1'b1;
      end

      ins_valid <= fetch_go;
      if (fetch_go) begin
        // A miss returns a NOP. The array is only indexed on a hit, which
        // guarantees fetch_addr < prog_count <= DEPTH.
        if (fetch_hit) begin
          ins_out  <= mem[fetch_addr[IDX_W-1:0]];
          addr_err <= 1'b0;
        end else begin
          ins_out  <= '0;
          addr_err <= 1'b1;
        end
      end else begin
        addr_err <= 1'b0;
      end
    end
  end

  // Storage is deliberately left unreset so that it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[IDX_W-1:0]] <= prog_data;
  end

endmodule

// File: tb/tb_instr_mem_prog.sv
// Bench for instr_mem_prog. Two instances share one stimulus stream:
// instance 0 uses DEPTH=256 and instance 1 uses DEPTH=4, which lets the
// full-memory case run alongside the normal flow. A behavioural model per
// instance keeps the session's loaded words and the read-back result. The
// model is compared against both DUTs on every falling edge. Literal
// expectations placed along the directed sequence pin the model itself.
module tb_instr_mem_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       prog_en = 1'b0;
  logic       prog_valid = 1'b0;
  logic [7:0] prog_data = 8'h00;
  logic       fetch_req = 1'b0;
  logic [7:0] fetch_addr = 8'h00;

  logic       d_ready [2];
  logic       d_ovf   [2];
  logic [8:0] d_count [2];
  logic [7:0] d_out   [2];
  logic       d_valid [2];
  logic       d_err   [2];
  logic       d_busy  [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_mem_prog #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) u_big (
    .clk(clk), .rst(rst), .prog_en(prog_en), .prog_valid(prog_valid),
    .prog_data(prog_data), .prog_ready(d_ready[0]), .prog_ovf(d_ovf[0]),
    .prog_count(d_count[0]), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .ins_out(d_out[0]), .ins_valid(d_valid[0]), .addr_err(d_err[0]),
    .busy(d_busy[0])
  );

  instr_mem_prog #(.DATA_W(8), .ADDR_W(8), .DEPTH(4)) u_small (
    .clk(clk), .rst(rst), .prog_en(prog_en), .prog_valid(prog_valid),
    .prog_data(prog_data), .prog_ready(d_ready[1]), .prog_ovf(d_ovf[1]),
    .prog_count(d_count[1]), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .ins_out(d_out[1]), .ins_valid(d_valid[1]), .addr_err(d_err[1]),
    .busy(d_busy[1])
  );

  // ---------------- behavioural model ----------------
  int         m_depth [2] = '{256, 4};
  bit         m_load  [2];
  int         m_n     [2];          // words loaded this session
  logic [7:0] m_words [2][256];     // words loaded this session, in order
  bit         m_ovf   [2];
  logic [7:0] m_out   [2];
  bit         m_valid [2];
  bit         m_err   [2];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_load[i] = 0; m_n[i] = 0; m_ovf[i] = 0;
        m_out[i] = 8'h00; m_valid[i] = 0; m_err[i] = 0;
      end else begin
        // Fetch result uses the session contents before this edge.
        if (!m_load[i] && fetch_req && !prog_en) begin
          m_valid[i] = 1;
          if (int'(fetch_addr) < m_n[i]) begin
            m_out[i] = m_words[i][fetch_addr];
            m_err[i] = 0;
          end else begin
            m_out[i] = 8'h00;
            m_err[i] = 1;
          end
        end else begin
          m_valid[i] = 0;
          m_err[i]   = 0;
        end
        if (!m_load[i]) begin
          if (prog_en) begin
            m_load[i] = 1; m_n[i] = 0; m_ovf[i] = 0;
          end
        end else begin
          if (prog_valid) begin
            if (m_n[i] < m_depth[i]) begin
              m_words[i][m_n[i]] = prog_data;
              m_n[i] = m_n[i] + 1;
            end else begin
              m_ovf[i] = 1;
            end
          end
          if (!prog_en) m_load[i] = 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge, every output of both instances.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("ready%0d", i), 32'(d_ready[i]),
            32'(m_load[i] && (m_n[i] < m_depth[i])));
      check($sformatf("ovf%0d", i),   32'(d_ovf[i]),   32'(m_ovf[i]));
      check($sformatf("count%0d", i), 32'(d_count[i]), 32'(m_n[i]));
      check($sformatf("out%0d", i),   32'(d_out[i]),   32'(m_out[i]));
      check($sformatf("valid%0d", i), 32'(d_valid[i]), 32'(m_valid[i]));
      check($sformatf("err%0d", i),   32'(d_err[i]),   32'(m_err[i]));
      check($sformatf("busy%0d", i),  32'(d_busy[i]),  32'(m_load[i]));
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] words [5] = '{8'h49, 8'h38, 8'h98, 8'hA2, 8'h67};

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(d_busy[0]), 32'd0);
    check("rst_count", 32'(d_count[0]), 32'd0);
    check("rst_ready", 32'(d_ready[0]), 32'd0);
    check("rst_out", 32'(d_out[0]), 32'd0);
    rst = 1'b0;

    // prog_valid while idle is ignored
    prog_valid = 1'b1; prog_data = 8'hFF;
    tick();
    check("idle_valid_ovf", 32'(d_ovf[0]), 32'd0);
    check("idle_valid_count", 32'(d_count[0]), 32'd0);
    prog_valid = 1'b0;

    // Load session with gaps in prog_valid
    prog_en = 1'b1;
    tick();
    check("load_busy", 32'(d_busy[0]), 32'd1);
    check("load_ready", 32'(d_ready[0]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      prog_valid = 1'b1; prog_data = words[k];
      tick();
      if (k == 1 || k == 3) begin
        prog_valid = 1'b0;
        tick();
      end
      if (k == 3) begin
        check("small_full_ready", 32'(d_ready[1]), 32'd0);
        check("big_ready", 32'(d_ready[0]), 32'd1);
        check("small_count4", 32'(d_count[1]), 32'd4);
      end
    end
    check("small_ovf", 32'(d_ovf[1]), 32'd1);
    check("big_ovf", 32'(d_ovf[0]), 32'd0);
    prog_valid = 1'b0; prog_en = 1'b0;
    check("busy_exit_cycle", 32'(d_busy[0]), 32'd1);
    tick();
    check("busy_after_exit", 32'(d_busy[0]), 32'd0);
    check("big_count5", 32'(d_count[0]), 32'd5);
    check("small_count_final", 32'(d_count[1]), 32'd4);

    // Back-to-back fetches
    for (int k = 0; k < 5; k++) begin
      fetch_req = 1'b1; fetch_addr = 8'(k);
      tick();
      check($sformatf("fetch_word%0d", k), 32'(d_out[0]), 32'(words[k]));
      check($sformatf("fetch_valid%0d", k), 32'(d_valid[0]), 32'd1);
      check($sformatf("fetch_err%0d", k), 32'(d_err[0]), 32'd0);
    end
    check("small_addr4_err", 32'(d_err[1]), 32'd1);
    fetch_addr = 8'd7;
    tick();
    check("addr7_out", 32'(d_out[0]), 32'h00);
    check("addr7_err", 32'(d_err[0]), 32'd1);
    check("addr7_valid", 32'(d_valid[0]), 32'd1);
    fetch_addr = 8'd2;
    tick();
    check("addr2_out", 32'(d_out[0]), 32'h98);
    check("addr2_err", 32'(d_err[0]), 32'd0);
    fetch_req = 1'b0;
    tick();
    check("hold_valid", 32'(d_valid[0]), 32'd0);
    check("hold_out", 32'(d_out[0]), 32'h98);

    // fetch_req held while a load starts
    fetch_req = 1'b1; fetch_addr = 8'd1;
    tick();
    check("pre_load_out", 32'(d_out[0]), 32'h38);
    prog_en = 1'b1;
    tick();
    check("prio_valid", 32'(d_valid[0]), 32'd0);
    check("prio_out", 32'(d_out[0]), 32'h38);
    check("new_load_ovf_clr", 32'(d_ovf[1]), 32'd0);
    tick();
    check("prio_valid2", 32'(d_valid[0]), 32'd0);
    prog_en = 1'b0;
    tick();
    check("exit_valid", 32'(d_valid[0]), 32'd0);
    tick();
    check("empty_fetch_err", 32'(d_err[0]), 32'd1);
    check("empty_fetch_out", 32'(d_out[0]), 32'h00);
    fetch_req = 1'b0;

    // Reset in the middle of a load
    prog_en = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      prog_valid = 1'b1; prog_data = 8'h11 * 8'(k + 1);
      tick();
    end
    check("pre_rst_count", 32'(d_count[0]), 32'd3);
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(d_busy[0]), 32'd0);
    check("arst_count", 32'(d_count[0]), 32'd0);
    check("arst_ready", 32'(d_ready[0]), 32'd0);
    check("arst_valid", 32'(d_valid[0]), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; prog_en = 1'b0; prog_valid = 1'b0;
    fetch_req = 1'b1; fetch_addr = 8'd0;
    tick();
    check("post_rst_err", 32'(d_err[0]), 32'd1);
    check("post_rst_out", 32'(d_out[0]), 32'h00);
    fetch_req = 1'b0;

    // Fresh load after reset, then read it back
    prog_en = 1'b1;
    tick();
    prog_valid = 1'b1; prog_data = 8'h5A;
    tick();
    prog_valid = 1'b0; prog_en = 1'b0;
    tick();
    fetch_req = 1'b1; fetch_addr = 8'd0;
    tick();
    check("reload_out", 32'(d_out[0]), 32'h5A);
    check("reload_err", 32'(d_err[0]), 32'd0);
    fetch_req = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_mem_prog.md
INSTR_MEM_PROG -- requirements
Module: instr_mem_prog

Interface
REQ-001 Parameter DATA_W, default 8: instruction word width in bits.
REQ-002 Parameter ADDR_W, default 8: address width in bits.
REQ-003 Parameter DEPTH, default 256: number of instruction words; legal range 2..2**ADDR_W.
REQ-004 Port clk  input  1: sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1: asynchronous, active-high reset.
REQ-006 Port prog_en  input  1: high = load session active.
REQ-007 Port prog_valid  input  1: prog_data holds a word to write.
REQ-008 Port prog_data  input  DATA_W: instruction word to load.
REQ-009 Port prog_ready  output  1: block accepts a load word this cycle.
REQ-010 Port prog_ovf  output  1: sticky flag; load word offered while memory full.
REQ-011 Port prog_count  output  ADDR_W+1: number of words loaded in the last completed or current session.
REQ-012 Port fetch_req  input  1: fetch request, sampled when in IDLE.
REQ-013 Port fetch_addr  input  ADDR_W: word address from PC.
REQ-014 Port ins_out  output  DATA_W: fetched instruction, registered.
REQ-015 Port ins_valid  output  1: one-cycle pulse; ins_out updated this cycle.
REQ-016 Port addr_err  output  1: qualifies ins_valid; fetched address not loaded.
REQ-017 Port busy  output  1: high while in LOAD.

Function
REQ-018 Two-state FSM: IDLE, LOAD; busy = (state == LOAD).
REQ-019 IDLE -> LOAD on a cycle with prog_en=1; entry clears wr_ptr, prog_count and prog_ovf to 0.
REQ-020 LOAD -> IDLE on the first cycle with prog_en=0; prog_count retains its final value.
REQ-021 In LOAD, prog_ready = (wr_ptr < DEPTH); combinational from state and wr_ptr; prog_ready = 0 in IDLE.
REQ-022 Write handshake: prog_valid && prog_ready at a clock edge -> mem[wr_ptr] <= prog_data, wr_ptr and prog_count increment by 1.
REQ-023 prog_valid=1 with prog_ready=0 in LOAD -> word dropped, prog_ovf <= 1 and held until next LOAD entry or reset.
REQ-024 prog_valid while in IDLE (prog_en=0) is ignored; no write, no flag.
REQ-025 Fetch: in IDLE with fetch_req=1 and prog_en=0, the next edge sets ins_valid=1 and ins_out <= mem[fetch_addr] when fetch_addr < prog_count; latency exactly 1 cycle; back-to-back requests give one result per cycle.
REQ-026 fetch_addr >= prog_count (including >= DEPTH) -> ins_out <= 0 (NOP), addr_err <= 1, ins_valid <= 1; no out-of-range array access.
REQ-027 addr_err <= 0 on every in-range fetch and whenever ins_valid is 0.
REQ-028 fetch_req in LOAD, or coincident with prog_en=1 in IDLE, is ignored: ins_valid <= 0; load takes priority.
REQ-029 When no fetch is accepted, ins_valid <= 0 and ins_out holds its last value.
REQ-030 Memory array is not reset; contents persist across sessions and are read back only below prog_count.
REQ-031 wr_ptr and prog_count are ADDR_W+1 bits so DEPTH = 2**ADDR_W is reachable without wrap; wr_ptr never wraps.

Reset
REQ-032 rst=1 asynchronously forces: state IDLE, wr_ptr 0, prog_count 0, prog_ovf 0, ins_out 0, ins_valid 0, addr_err 0; prog_ready 0, busy 0.
REQ-033 Reset during LOAD aborts the session; words already written remain in the array but are unreachable (prog_count = 0).
REQ-034 After rst deasserts, the first edge behaves per REQ-019/REQ-025 with no extra latency.

Verification
REQ-035 Load 0x49,0x38,0x98,0xA2,0x67, drop prog_en -> prog_count=5, busy falls the cycle after prog_en falls; fetches at addresses 0..4 return the same words, each with ins_valid one cycle after fetch_req, addr_err=0.
REQ-036 After REQ-035 load, fetch address 7 -> ins_out=0x00, ins_valid=1, addr_err=1; next fetch at address 2 -> 0x98, addr_err=0.
REQ-037 DEPTH=4: offer 5 words -> first 4 accepted, prog_ready=0 after 4th, prog_ovf=1, prog_count=4; new LOAD entry clears prog_ovf.
REQ-038 Assert fetch_req continuously while raising prog_en -> ins_valid=0 from the first prog_en cycle until the cycle after LOAD exit; no stale ins_out change.
REQ-039 Assert rst mid-load after 3 words -> all outputs at reset values immediately; fetch address 0 -> addr_err=1, ins_out=0.
REQ-040 prog_valid toggling with gaps during LOAD -> only handshake cycles write; wr_ptr sequence contiguous with no skipped addresses.
